dot_product_acc: RTL
====================

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

Interface
REQ-001 The block SHALL have parameter LEN, default 4, giving operand pairs per dot product (legal 1..16).
REQ-002 The block SHALL have parameter ACC_W, default 12, giving the result width (legal 8..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand pair a/b is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-007 The block SHALL have port a, input, 4 bits: unsigned multiplicand.
REQ-008 The block SHALL have port b, input, 4 bits: unsigned multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_sum/out_ovf hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_sum, output, ACC_W bits: the accumulated sum of LEN products, saturated.
REQ-012 The block SHALL have port out_ovf, output, 1 bit: the true sum exceeded 2^ACC_W-1.

Function
REQ-013 A pair SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-014 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 In ACCUM, each accepted pair SHALL add the 8-bit product a*b to an internal accumulator ACC_W+1 bits wide and increment a beat counter.
REQ-016 When in_valid=0 in ACCUM, the accumulator and counter SHALL hold their values; gaps of any length are legal.
REQ-017 On acceptance of beat number LEN, the block SHALL, at the next edge:
- register the final sum into out_sum/out_ovf;
- clear the accumulator and counter;
- enter HOLD.
REQ-018 Latency SHALL be one cycle: out_valid rises in the cycle after the LEN-th pair is accepted.
REQ-019 If the final sum is greater than 2^ACC_W-1, out_sum SHALL be all-ones and out_ovf=1; otherwise out_sum is the exact sum and out_ovf=0.
REQ-020 In HOLD, out_sum and out_ovf SHALL remain stable until out_valid=1 and out_ready=1 occur in the same cycle; the block then returns to ACCUM at the next edge.
REQ-021 in_ready SHALL be 0 for the whole of HOLD, including the handshake cycle, giving a one-cycle minimum gap between results.
REQ-022 With LEN=1, every accepted pair SHALL produce a result (ACCUM -> HOLD every accept).
REQ-023 Inputs a/b SHALL be ignored whenever no acceptance occurs; X on a/b while in_valid=0 SHALL NOT corrupt state.

Reset
REQ-024 While rst=1, the block SHALL be in state ACCUM with in_ready=1, out_valid=0, out_sum=0, out_ovf=0, accumulator=0 and counter=0.
REQ-025 Reset asserted mid-accumulation or during HOLD SHALL discard the partial sum or pending result immediately, without waiting for a clock edge.
REQ-026 The first pair accepted after reset deasserts SHALL be beat 1 of a new dot product.

Structure
REQ-027 A shared package dot_pkg SHALL hold:
- the state enum (ACCUM, HOLD);
- default constants for LEN and ACC_W;
- the product width constant (8).
REQ-028 The product SHALL come from one instance of the existing combinational multiplier_4x4 (A=a, B=b, P); no other sub-module.
REQ-029 The counter width SHALL be $clog2(LEN+1), and all registers SHALL use the asynchronous reset.

Verification
REQ-030 The bench SHALL cover basic accumulation: LEN=4, ACC_W=12, pairs (3,2),(5,5),(15,15),(0,10) back-to-back -> out_valid one cycle after the 4th accept, out_sum=256, out_ovf=0.
REQ-031 The bench SHALL cover backpressure: hold out_ready=0 for 3 cycles after a result of 256 -> out_sum stays 256 and in_ready=0 throughout; handshake, then ACCUM the next cycle.
REQ-032 The bench SHALL cover input gaps: pairs (7,1) x4 with in_valid=0 for 2 cycles between each -> out_sum=28.
REQ-033 The bench SHALL cover saturation: LEN=2, ACC_W=8, pairs (15,15),(15,15) -> out_sum=255, out_ovf=1; next set (1,1),(2,2) -> out_sum=5, out_ovf=0.
REQ-034 The bench SHALL cover reset mid-operation: accept (15,15),(15,15), pulse rst, then accept (7,1) x4 -> out_sum=28, with no residual 450.
REQ-035 The bench SHALL cover LEN=1: pairs (3,2) then (5,5) with out_ready=1 -> two results, 6 then 25, two cycles apart at minimum.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product accumulator: controller states,
// default geometry and the fixed 4x4 product width.
package dot_pkg;

  localparam int DEF_LEN   = 4;
  localparam int DEF_ACC_W = 12;
  localparam int PROD_W    = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/multiplier_4x4.sv
// Combinational unsigned 4x4 multiplier producing a full 8-bit product.
module multiplier_4x4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  assign P = {4'b0000, A} * {4'b0000, B};

endmodule

// File: rtl/dot_product_acc.sv
// Accumulates LEN unsigned 4x4 products into a saturating ACC_W-bit result
// and holds each result until the consumer handshakes it away.
module dot_product_acc
  import dot_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam int SUM_W = ACC_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum_raw;
  logic [ACC_W:0]    sum_sat;
  logic              accept;
  logic              last_beat;
  logic              take;

  multiplier_4x4 u_mul (
    .A (a),
    .B (b),
    .P (prod)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (cnt_q == LAST_BEAT);
  assign take      = out_valid & out_ready;

  // Bit ACC_W of the accumulator acts as a sticky overflow flag; clamping it at
  // 2^ACC_W keeps long, large sums from wrapping back into the legal range.
  always_comb begin
    sum_raw = SUM_W'(acc_q) + SUM_W'(prod);
    if (sum_raw[SUM_W-1:ACC_W] != '0) begin
      sum_sat = {1'b1, {ACC_W{1'b0}}};
    end else begin
      sum_sat = sum_raw[ACC_W:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (last_beat) begin
          acc_d     = '0;
          cnt_d     = '0;
          out_ovf_d = sum_sat[ACC_W];
          out_sum_d = sum_sat[ACC_W] ? {ACC_W{1'b1}} : sum_sat[ACC_W-1:0];
          state_d   = HOLD;
        end else if (accept) begin
          acc_d = sum_sat;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (take) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule
